// File: rtl/ctrl_word_pkg.sv
// rtl/ctrl_word_pkg.sv - shared definitions for the stage-2 control word consumer
// Purpose: bit positions of the 13-bit control word, write-back source codes
//          and the hold/bubble FSM state type.
// Ports:   none (package).
package ctrl_word_pkg;

  localparam int CW_W    = 13;

  // Word layout {BB2,ER0,ERN,XR0,SOD,ISP,ESP,EIP,LPC,FLR0,XRN,X4SP,XWR}
  localparam int CW_BB2  = 12;
  localparam int CW_ER0  = 11;
  localparam int CW_ERN  = 10;
  localparam int CW_XR0  = 9;
  localparam int CW_SOD  = 8;
  localparam int CW_ISP  = 7;
  localparam int CW_ESP  = 6;
  localparam int CW_EIP  = 5;
  localparam int CW_LPC  = 4;
  localparam int CW_FLR0 = 3;
  localparam int CW_XRN  = 2;
  localparam int CW_X4SP = 1;
  localparam int CW_XWR  = 0;

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_PORT = 2'd1;
  localparam logic [1:0] WB_SRC_MEM  = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OPSKIP = 2'd1,
    STALL  = 2'd2
  } exec_state_t;

endpackage

// File: rtl/ctrl_word_executor_if.sv
// rtl/ctrl_word_executor_if.sv - stage-2 to stage-3 control word handshake
// Purpose: carries the control word, its RN index and valid from stage 2,
//          and the hold back-pressure from the executor.
// Ports:   ctl_valid, ctl_word[12:0], ctl_rn[RN_W-1:0] (stage 2 -> executor),
//          hold (executor -> stage 2).
// Modports: master = stage 2 producer, slave = executor.
interface ctrl_word_executor_if #(
  parameter int RN_W = 3
) ();
  import ctrl_word_pkg::*;

  logic              ctl_valid;
  logic [CW_W-1:0]   ctl_word;
  logic [RN_W-1:0]   ctl_rn;
  logic              hold;

  modport master (output ctl_valid, output ctl_word, output ctl_rn, input hold);
  modport slave  (input ctl_valid, input ctl_word, input ctl_rn, output hold);

endinterface

// File: rtl/ctrl_sp_unit.sv
// rtl/ctrl_sp_unit.sv - stack pointer register with pop/push/load priority
// Purpose: SP register; WB load beats the EX inc/dec in the same cycle.
//          Optional overflow guard selected by macro CTRL_SP_GUARD_EN.
// Ports:   clk, rst (sync, active-high), i_inc (pop), i_dec (push),
//          i_ld / i_ld_data (X4SP load), o_sp, o_fault (sticky guard fault).
module ctrl_sp_unit #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic              i_ld,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic [DATA_W-1:0] o_sp,
  output logic              o_fault
);

  logic [DATA_W-1:0] r_sp;

`ifdef CTRL_SP_GUARD_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp    <= SP_RESET;
      r_fault <= 1'b0;
    end else if (i_ld) begin
      r_sp <= i_ld_data;
    end else if (i_inc) begin
      // Pop from an empty stack: flag it and leave SP untouched.
      if (r_sp == SP_RESET) r_fault <= 1'b1;
      else                  r_sp    <= r_sp + DATA_W'(1);
    end else if (i_dec) begin
      if (r_sp == '0) r_fault <= 1'b1;
      else            r_sp    <= r_sp - DATA_W'(1);
    end
  end

  assign o_fault = r_fault;
`else
  always_ff @(posedge clk) begin
    if (rst)        r_sp <= SP_RESET;
    else if (i_ld)  r_sp <= i_ld_data;
    else if (i_inc) r_sp <= r_sp + DATA_W'(1);
    else if (i_dec) r_sp <= r_sp - DATA_W'(1);
  end

  assign o_fault = 1'b0;
`endif

  assign o_sp = r_sp;

endmodule

// File: rtl/ctrl_word_executor.sv
// rtl/ctrl_word_executor.sv - EX/WB consumer of the stage-2 control word
// Purpose: latches control words into EX and WB, decodes register-file write
//          enables, SP updates, PC load and memory strobes, and drives hold
//          back to stage 2 (operand skip after BB2, load-use stall, flush).
// Ports:   clk, rst (sync, active-high); ctl (slave handshake: valid/word/rn
//          in, hold out); i_cond_true (EX), i_sp_ld_data (WB);
//          o_r0_we, o_rn_we, o_rn_wsel, o_wb_src, o_mem_we (registered WB);
//          o_pc_load, o_fwd_r0 (EX); o_sp, o_sp_fault.
// Config:  macro CTRL_SP_GUARD_EN enables the SP wrap guard in ctrl_sp_unit.
module ctrl_word_executor
  import ctrl_word_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF,
  parameter int                RN_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_word_executor_if.slave   ctl,
  input  logic                  i_cond_true,
  input  logic [DATA_W-1:0]     i_sp_ld_data,
  output logic                  o_r0_we,
  output logic                  o_rn_we,
  output logic [RN_W-1:0]       o_rn_wsel,
  output logic [1:0]            o_wb_src,
  output logic                  o_mem_we,
  output logic                  o_pc_load,
  output logic                  o_fwd_r0,
  output logic [DATA_W-1:0]     o_sp,
  output logic                  o_sp_fault
);

  exec_state_t       r_state;
  logic              r_ex_valid;
  logic [CW_W-1:0]   r_ex_word;
  logic [RN_W-1:0]   r_ex_rn;
  logic              r_wb_x4sp;

  logic w_flush;
  logic w_hazard;
  logic w_stall;
  logic w_accept;
  logic w_ex_rn_wr;
  logic w_ex_r0_wr;
  logic w_unused;

  // A taken PC load in EX squashes whatever stage 2 is presenting.
  assign w_flush = r_ex_valid && r_ex_word[CW_LPC] && i_cond_true;

  // Load-use: the EX word fetches from memory into a register that the
  // incoming word wants to use as an ALU operand.
  assign w_hazard = r_ex_valid &&
                    ((r_ex_word[CW_XRN] && ctl.ctl_word[CW_ERN] && (ctl.ctl_rn == r_ex_rn)) ||
                     (r_ex_word[CW_XR0] && ctl.ctl_word[CW_ER0]));

  assign w_stall  = (r_state == RUN) && ctl.ctl_valid && w_hazard && !w_flush;
  assign ctl.hold = w_stall;

  // In OPSKIP the presented word is the operand byte and is dropped.
  assign w_accept = ctl.ctl_valid && !w_flush && !w_stall && (r_state != OPSKIP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else if (w_flush) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_stall)                                r_state <= STALL;
          else if (w_accept && ctl.ctl_word[CW_BB2])  r_state <= OPSKIP;
        end
        STALL: begin
          if (w_accept && ctl.ctl_word[CW_BB2]) r_state <= OPSKIP;
          else                                  r_state <= RUN;
        end
        OPSKIP: begin
          if (ctl.ctl_valid) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // EX stage: a rejected/dropped word becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_word  <= '0;
      r_ex_rn    <= '0;
    end else begin
      r_ex_valid <= w_accept;
      r_ex_word  <= ctl.ctl_word;
      r_ex_rn    <= ctl.ctl_rn;
    end
  end

  assign w_ex_rn_wr = r_ex_valid && (r_ex_word[CW_ERN] || r_ex_word[CW_XRN]);
  // RN index 0 is R0, so an RN write there also raises the R0 enable.
  assign w_ex_r0_wr = r_ex_valid && (r_ex_word[CW_ER0] || r_ex_word[CW_XR0] ||
                                     (w_ex_rn_wr && (r_ex_rn == '0)));

  // WB stage outputs, registered from EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r0_we   <= 1'b0;
      o_rn_we   <= 1'b0;
      o_rn_wsel <= '0;
      o_wb_src  <= WB_SRC_ALU;
      o_mem_we  <= 1'b0;
      r_wb_x4sp <= 1'b0;
    end else begin
      o_r0_we   <= w_ex_r0_wr;
      o_rn_we   <= w_ex_rn_wr;
      o_rn_wsel <= w_ex_rn_wr ? r_ex_rn : '0;
      if (r_ex_valid && (r_ex_word[CW_XR0] || r_ex_word[CW_XRN])) o_wb_src <= WB_SRC_MEM;
      else if (r_ex_valid && r_ex_word[CW_EIP])                    o_wb_src <= WB_SRC_PORT;
      else                                                         o_wb_src <= WB_SRC_ALU;
      o_mem_we  <= r_ex_valid && r_ex_word[CW_XWR];
      r_wb_x4sp <= r_ex_valid && r_ex_word[CW_X4SP];
    end
  end

  assign o_pc_load = w_flush;
  assign o_fwd_r0  = r_ex_valid && r_ex_word[CW_FLR0];

  ctrl_sp_unit #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (r_ex_valid && r_ex_word[CW_ESP] && r_ex_word[CW_ISP]),
    .i_dec     (r_ex_valid && r_ex_word[CW_ESP] && !r_ex_word[CW_ISP]),
    .i_ld      (r_wb_x4sp),
    .i_ld_data (i_sp_ld_data),
    .o_sp      (o_sp),
    .o_fault   (o_sp_fault)
  );

  // BB2 only matters at accept time; SOD is consumed elsewhere in the pipe.
  assign w_unused = r_ex_word[CW_BB2] ^ r_ex_word[CW_SOD];

endmodule
